// File: rtl/config_pkg.sv
// Shared definitions for the serial configuration loader.
// Holds bus widths, frame layout, config field offsets and the loader FSM state type.
package config_pkg;

    localparam int CFG_ADDR_W  = 6;
    localparam int CFG_DATA_W  = 8;
    localparam int CFG_FRAME_W = 15;

    // Field offsets inside config_data[0:7]
    localparam int CFG_LSEL_LO = 0;
    localparam int CFG_LSEL_HI = 2;
    localparam int CFG_RSEL_LO = 3;
    localparam int CFG_RSEL_HI = 5;
    localparam int CFG_OSEL_LO = 6;
    localparam int CFG_OSEL_HI = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

endpackage

// File: rtl/config_loader_if.sv
// Programming-side handshake plus the shared compute-block config bus.
// master: programming source (start, bit_in, bit_valid); slave: the loader.
interface config_loader_if #(
    parameter int ADDR_W = config_pkg::CFG_ADDR_W,
    parameter int DATA_W = config_pkg::CFG_DATA_W
);

    logic              start;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic              config_en;
    logic [ADDR_W-1:0] config_addr;
    logic [0:DATA_W-1] config_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        frames_written;

    modport master (
        output start, bit_in, bit_valid,
        input  bit_ready, config_en, config_addr, config_data,
        input  busy, done, error, frames_written
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output bit_ready, config_en, config_addr, config_data,
        output busy, done, error, frames_written
    );

endinterface

// File: rtl/config_loader_frame_shifter.sv
// Frame assembly: 15-bit shift register, bit counter, full flag, running parity.
// Ports: i_clr clears all, i_shift shifts i_bit in; o_frame/o_last/o_full/o_par.
module frame_shifter
    import config_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_shift,
    input  logic                   i_bit,
    output logic [CFG_FRAME_W-1:0] o_frame,
    output logic                   o_last,
    output logic                   o_full,
    output logic                   o_par
);

    logic [CFG_FRAME_W-1:0] r_frame;
    logic [3:0]             r_cnt;
    logic                   r_full;
    logic                   r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_par   <= 1'b0;
        end else if (i_clr) begin
            r_frame <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_par   <= 1'b0;
        end else if (i_shift) begin
            r_frame <= {r_frame[CFG_FRAME_W-2:0], i_bit};
            r_cnt   <= r_cnt + 4'd1;
            r_full  <= o_last;
            r_par   <= r_par ^ i_bit;
        end
    end

    assign o_frame = r_frame;
    assign o_last  = (r_cnt == 4'(CFG_FRAME_W - 1));
    assign o_full  = r_full;
    assign o_par   = r_par;

endmodule

// File: rtl/config_loader.sv
// Serial bitstream loader: assembles 15-bit frames and writes them to the block array.
// Ports: clk, rst_n (async, active-low), bus (config_loader_if.slave).
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int ADDR_W     = CFG_ADDR_W,
    parameter int DATA_W     = CFG_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    config_loader_if.slave bus
);

    ld_state_t r_state;
    ld_state_t w_nxt;

    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   r_cfg_en;
    logic [ADDR_W-1:0]      r_addr;
    logic [0:DATA_W-1]      r_data;
    logic [7:0]             r_frames;

    logic [CFG_FRAME_W-1:0] w_frame;
    logic [CFG_FRAME_W-1:0] w_frame_nxt;
    logic                   w_last;
    logic                   w_full;
    logic                   w_par;
    logic                   w_shift;
    logic                   w_start_ok;
    logic                   w_good;

    frame_shifter u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state != ST_LOAD),
        .i_shift (w_shift),
        .i_bit   (bus.bit_in),
        .o_frame (w_frame),
        .o_last  (w_last),
        .o_full  (w_full),
        .o_par   (w_par)
    );

    assign w_shift     = r_ready & bus.bit_valid;
    assign w_frame_nxt = {w_frame[CFG_FRAME_W-2:0], bus.bit_in};
    assign w_start_ok  = bus.start &
                         ((r_state == ST_IDLE) | (r_state == ST_ERROR));
    // Write is launched on the bit-14 handshake so config_en lands in WRITE
    assign w_good      = w_shift & w_last & ~(w_par ^ bus.bit_in);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_nxt = ST_LOAD;
            ST_LOAD:  if (w_shift && w_last) w_nxt = ST_WRITE;
            ST_WRITE: begin
                if (w_full && !w_par)
                    w_nxt = (r_frames == 8'(NUM_FRAMES)) ? ST_DONE : ST_LOAD;
                else
                    w_nxt = ST_ERROR;
            end
            ST_DONE:  w_nxt = ST_IDLE;
            ST_ERROR: if (bus.start) w_nxt = ST_LOAD;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    // Status outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_cfg_en <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_frames <= '0;
        end else begin
            r_ready  <= (w_nxt == ST_LOAD);
            r_busy   <= (w_nxt == ST_LOAD) | (w_nxt == ST_WRITE);
            r_done   <= (w_nxt == ST_DONE);
            r_error  <= (w_nxt == ST_ERROR);
            r_cfg_en <= w_good;
            if (w_good) begin
                r_addr <= w_frame_nxt[CFG_FRAME_W-1 -: ADDR_W];
                r_data <= w_frame_nxt[CFG_FRAME_W-1-ADDR_W -: DATA_W];
            end
            if (w_start_ok)  r_frames <= '0;
            else if (w_good) r_frames <= r_frames + 8'd1;
        end
    end

    assign bus.bit_ready      = r_ready;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.config_en      = r_cfg_en;
    assign bus.config_addr    = r_addr;
    assign bus.config_data    = r_data;
    assign bus.frames_written = r_frames;

endmodule
